call_dispatcher: RTL and testbench

Request-side front end for the elevator's movement controller. Latches interior and exterior floor-call buttons into a pending set and applies a SCAN (collective) policy to pick the next target floor. Presents that floor to the movement controller through a valid/served handshake, and clears each call when the car reports it has served that floor. Sits between the button panels and the movement controller; interior calls are gated by the management login flag.

---
 rtl/call_dispatcher.sv | 160 ++++++++++++++++
 tb/tb_call_dispatcher.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/call_dispatcher.sv
// Elevator call dispatcher: latches floor-call buttons into a pending set and
// hands the next SCAN target to the movement controller over valid/served.
module call_dispatcher #(
    parameter int unsigned FLOORS = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [FLOORS-1:0] in_btn,
    input  logic [FLOORS-1:0] ex_btn,
    input  logic              logged_in,
    input  logic [2:0]        cur_floor,
    input  logic              served,
    output logic [2:0]        req_floor,
    output logic              req_valid,
    output logic [FLOORS-1:0] pending,
    output logic [1:0]        dir
);

    localparam int unsigned FW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } dir_t;

    dir_t              state;
    logic [FLOORS-1:0] in_q;
    logic [FLOORS-1:0] ex_q;

    logic [FLOORS-1:0] press_c;
    logic [FLOORS-1:0] clr_c;
    logic [FLOORS-1:0] pending_nxt_c;
    logic              accept_c;

    logic              here_f_c;
    logic              lo_gt_f_c;
    logic              hi_lt_f_c;
    logic [FW-1:0]     lo_gt_c;
    logic [FW-1:0]     hi_lt_c;
    logic [FW-1:0]     du_c;
    logic [FW-1:0]     dd_c;
    logic              pick_up_c;

    assign dir = state;

    // Call capture: rising edges set pending, an accepted serve clears its floor.
    always_comb begin
        accept_c = served && req_valid && (cur_floor == req_floor);
        press_c  = (ex_btn & ~ex_q) | (in_btn & ~in_q & {FLOORS{logged_in}});
        clr_c    = '0;
        for (int i = 0; i < int'(FLOORS); i++) begin
            clr_c[i] = accept_c && (req_floor == FW'(i));
        end
        pending_nxt_c = (pending | press_c) & ~clr_c;
    end

    // Nearest pending floor strictly above / strictly below / at cur_floor.
    always_comb begin
        here_f_c  = 1'b0;
        lo_gt_f_c = 1'b0;
        hi_lt_f_c = 1'b0;
        lo_gt_c   = '0;
        hi_lt_c   = '0;
        for (int i = int'(FLOORS) - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                lo_gt_f_c = 1'b1;
                lo_gt_c   = FW'(i);
            end
        end
        for (int i = 0; i < int'(FLOORS); i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                hi_lt_f_c = 1'b1;
                hi_lt_c   = FW'(i);
            end
            if (pending[i] && (i == int'(cur_floor))) begin
                here_f_c = 1'b1;
            end
        end
        du_c      = lo_gt_c - cur_floor;
        dd_c      = cur_floor - hi_lt_c;
        pick_up_c = lo_gt_f_c && (!hi_lt_f_c || (du_c <= dd_c));
    end

    // Direction FSM and request handshake; targets chosen only while req_valid is low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            in_q      <= '0;
            ex_q      <= '0;
            pending   <= '0;
            req_floor <= '0;
            req_valid <= 1'b0;
            state     <= IDLE;
        end else begin
            in_q    <= in_btn;
            ex_q    <= ex_btn;
            pending <= pending_nxt_c;
            if (accept_c) begin
                req_valid <= 1'b0;
            end else if (req_valid) begin
                // Retarget only toward a floor strictly between car and target.
                if (state == UP && lo_gt_f_c && (lo_gt_c < req_floor)) begin
                    req_floor <= lo_gt_c;
                end else if (state == DOWN && hi_lt_f_c && (hi_lt_c > req_floor)) begin
                    req_floor <= hi_lt_c;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (here_f_c) begin
                            req_floor <= cur_floor;
                            req_valid <= 1'b1;
                        end else if (lo_gt_f_c || hi_lt_f_c) begin
                            req_valid <= 1'b1;
                            if (pick_up_c) begin
                                req_floor <= lo_gt_c;
                                state     <= UP;
                            end else begin
                                req_floor <= hi_lt_c;
                                state     <= DOWN;
                            end
                        end
                    end
                    UP: begin
                        if (here_f_c) begin
                            req_floor <= cur_floor;
                            req_valid <= 1'b1;
                        end else if (lo_gt_f_c) begin
                            req_floor <= lo_gt_c;
                            req_valid <= 1'b1;
                        end else if (hi_lt_f_c) begin
                            req_floor <= hi_lt_c;
                            req_valid <= 1'b1;
                            state     <= DOWN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DOWN: begin
                        if (here_f_c) begin
                            req_floor <= cur_floor;
                            req_valid <= 1'b1;
                        end else if (hi_lt_f_c) begin
                            req_floor <= hi_lt_c;
                            req_valid <= 1'b1;
                        end else if (lo_gt_f_c) begin
                            req_floor <= lo_gt_c;
                            req_valid <= 1'b1;
                            state     <= UP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_call_dispatcher.sv
// Directed bench for call_dispatcher with hand-computed expectations.
module tb_call_dispatcher;

    logic       CLK;
    logic       RST;
    logic [7:0] in_btn;
    logic [7:0] ex_btn;
    logic       logged_in;
    logic [2:0] cur_floor;
    logic       served;
    logic [2:0] req_floor;
    logic       req_valid;
    logic [7:0] pending;
    logic [1:0] dir;

    int errors = 0;
    int checks = 0;

    call_dispatcher #(.FLOORS(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_btn    (in_btn),
        .ex_btn    (ex_btn),
        .logged_in (logged_in),
        .cur_floor (cur_floor),
        .served    (served),
        .req_floor (req_floor),
        .req_valid (req_valid),
        .pending   (pending),
        .dir       (dir)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        in_btn    = '0;
        ex_btn    = '0;
        served    = 1'b0;
        RST       = 1'b0;
        #2;
        RST       = 1'b1;
        step();
    endtask

    task automatic serve_at(input logic [2:0] f);
        cur_floor = f;
        served    = 1'b1;
        step();
        served    = 1'b0;
    endtask

    initial begin
        RST       = 1'b0;
        in_btn    = '0;
        ex_btn    = '0;
        logged_in = 1'b0;
        cur_floor = 3'd0;
        served    = 1'b0;
        #23;
        check("rst_req_floor", 32'(req_floor), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_pending",   32'(pending),   32'h00);
        check("rst_dir",       32'(dir),       32'd0);
        RST = 1'b1;
        step();

        // Basic call
        cur_floor = 3'd0;
        ex_btn[3] = 1'b1;
        step();
        ex_btn[3] = 1'b0;
        check("basic_pending",   32'(pending),   32'h08);
        check("basic_valid_lat", 32'(req_valid), 32'd0);
        step();
        check("basic_req_floor", 32'(req_floor), 32'd3);
        check("basic_req_valid", 32'(req_valid), 32'd1);
        check("basic_dir",       32'(dir),       32'b01);
        serve_at(3'd3);
        check("basic_srv_pending", 32'(pending),   32'h00);
        check("basic_srv_valid",   32'(req_valid), 32'd0);
        step();
        check("basic_idle_dir",   32'(dir),       32'b00);
        check("basic_idle_valid", 32'(req_valid), 32'd0);

        // Login gating
        do_reset();
        cur_floor = 3'd3;
        logged_in = 1'b0;
        in_btn[5] = 1'b1;
        step();
        in_btn[5] = 1'b0;
        step();
        check("login_off_pending", 32'(pending),   32'h00);
        check("login_off_valid",   32'(req_valid), 32'd0);
        logged_in = 1'b1;
        in_btn[5] = 1'b1;
        step();
        in_btn[5] = 1'b0;
        check("login_on_pending", 32'(pending), 32'h20);
        step();
        check("login_req_floor", 32'(req_floor), 32'd5);
        check("login_dir",       32'(dir),       32'b01);

        // SCAN order 4, 6, 1 starting upward from floor 2
        do_reset();
        cur_floor = 3'd2;
        ex_btn[4] = 1'b1;
        step();
        ex_btn[4] = 1'b0;
        step();
        check("scan_first_req", 32'(req_floor), 32'd4);
        check("scan_first_dir", 32'(dir),       32'b01);
        ex_btn[6] = 1'b1;
        ex_btn[1] = 1'b1;
        step();
        ex_btn = '0;
        check("scan_pending", 32'(pending), 32'h52);
        step();
        check("scan_hold_req", 32'(req_floor), 32'd4);
        serve_at(3'd4);
        check("scan_after4_pending", 32'(pending), 32'h42);
        step();
        check("scan_second_req",   32'(req_floor), 32'd6);
        check("scan_second_valid", 32'(req_valid), 32'd1);
        check("scan_second_dir",   32'(dir),       32'b01);
        serve_at(3'd6);
        check("scan_after6_pending", 32'(pending), 32'h02);
        step();
        check("scan_third_req", 32'(req_floor), 32'd1);
        check("scan_third_dir", 32'(dir),       32'b10);
        serve_at(3'd1);
        step();
        check("scan_end_pending", 32'(pending), 32'h00);
        check("scan_end_dir",     32'(dir),     32'b00);

        // Retarget toward a floor between car and target
        do_reset();
        cur_floor = 3'd3;
        ex_btn[6] = 1'b1;
        step();
        ex_btn[6] = 1'b0;
        step();
        check("rt_initial_req", 32'(req_floor), 32'd6);
        ex_btn[5] = 1'b1;
        step();
        ex_btn[5] = 1'b0;
        check("rt_mid_valid", 32'(req_valid), 32'd1);
        step();
        check("rt_new_req",   32'(req_floor), 32'd5);
        check("rt_new_valid", 32'(req_valid), 32'd1);
        ex_btn[2] = 1'b1;
        step();
        ex_btn[2] = 1'b0;
        step();
        check("rt_behind_req", 32'(req_floor), 32'd5);
        check("rt_pending",    32'(pending),   32'h64);

        // Equal-distance tie goes up; mismatched served is ignored
        do_reset();
        cur_floor = 3'd4;
        ex_btn[2] = 1'b1;
        ex_btn[6] = 1'b1;
        step();
        ex_btn = '0;
        step();
        check("tie_req", 32'(req_floor), 32'd6);
        check("tie_dir", 32'(dir),       32'b01);
        serve_at(3'd4);
        check("badsrv_pending", 32'(pending),   32'h44);
        check("badsrv_valid",   32'(req_valid), 32'd1);
        check("badsrv_req",     32'(req_floor), 32'd6);

        // Held button yields a single call
        do_reset();
        cur_floor = 3'd0;
        ex_btn[7] = 1'b1;
        step();
        step();
        check("held_req", 32'(req_floor), 32'd7);
        serve_at(3'd7);
        step();
        step();
        check("held_pending", 32'(pending),   32'h00);
        check("held_valid",   32'(req_valid), 32'd0);
        ex_btn = '0;

        // Press for the served floor in the accept cycle is absorbed
        do_reset();
        cur_floor = 3'd0;
        ex_btn[3] = 1'b1;
        step();
        ex_btn[3] = 1'b0;
        step();
        cur_floor = 3'd3;
        ex_btn[3] = 1'b1;
        ex_btn[1] = 1'b1;
        served    = 1'b1;
        step();
        served    = 1'b0;
        ex_btn    = '0;
        check("absorb_pending", 32'(pending), 32'h02);
        step();
        check("absorb_next_req", 32'(req_floor), 32'd1);
        check("absorb_next_dir", 32'(dir),       32'b10);

        // Asynchronous reset with a request in flight
        do_reset();
        cur_floor = 3'd0;
        ex_btn[7] = 1'b1;
        ex_btn[0] = 1'b1;
        step();
        ex_btn = '0;
        step();
        check("mid_pending", 32'(pending),   32'h81);
        check("mid_valid",   32'(req_valid), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check("async_pending", 32'(pending),   32'h00);
        check("async_valid",   32'(req_valid), 32'd0);
        check("async_req",     32'(req_floor), 32'd0);
        check("async_dir",     32'(dir),       32'd0);
        #3;
        RST = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
